inv_mix_columns_pipe: RTL and testbench

//  Decryption-side InvMixColumns (FIPS-197 5.3.3) on one 32-bit state column per transfer.
//  Two-stage elastic pipeline with valid/ready handshake at both ends.

---
 rtl/inv_mix_columns_pipe.sv | 109 ++++++++++
 tb/tb_inv_mix_columns_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_pipe.sv
// InvMixColumns on one 32-bit column per transfer; 2-cycle latency, 1 word/clk.
// Elastic two-stage valid/ready pipeline; in_rdy follows out_rdy combinationally so bubbles collapse.
module inv_mix_columns_pipe #(
  parameter int WORDS_PER_STATE = 4,
  parameter int CNT_W           = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      word_in_inv_sub_bytes,
  input  logic             word_in_inv_sub_bytes_vld,
  output logic             word_in_inv_sub_bytes_rdy,
  input  logic             inv_mix_column_off,
  output logic [31:0]      word_out_inv_mix_column,
  output logic             word_out_inv_mix_column_vld,
  input  logic             word_out_inv_mix_column_rdy,
  output logic [CNT_W-1:0] word_out_col_idx,
  output logic             state_done
);

  // Byte 0 of each packed column is the most significant byte (a0 = [31:24]).
  typedef logic [0:3][7:0] col_t;

  typedef struct packed {
    col_t a;
    col_t x2;
    col_t x4;
    col_t x8;
    logic off;
  } s1_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WORDS_PER_STATE - 1);

  s1_t              s1;
  s1_t              s1_nxt;
  logic             s1_vld;
  logic [31:0]      s2_dat;
  logic             s2_vld;
  logic [CNT_W-1:0] col_cnt;

  col_t k9, kb, kd, ke, r;
  logic [31:0] s2_nxt;
  logic        adv1, adv2, out_xfer;

  assign adv2     = !s2_vld || word_out_inv_mix_column_rdy;
  assign adv1     = !s1_vld || adv2;
  assign out_xfer = s2_vld && word_out_inv_mix_column_rdy;

  assign word_in_inv_sub_bytes_rdy   = adv1;
  assign word_out_inv_mix_column_vld = s2_vld;
  assign word_out_inv_mix_column     = s2_vld ? s2_dat : 32'h0;
  assign word_out_col_idx            = col_cnt;
  assign state_done                  = s2_vld && (col_cnt == LAST_COL);

  always_comb begin
    s1_nxt     = '0;
    s1_nxt.a   = word_in_inv_sub_bytes;
    s1_nxt.off = inv_mix_column_off;
    for (int i = 0; i < 4; i++) begin
      s1_nxt.x2[i] = xtime(s1_nxt.a[i]);
      s1_nxt.x4[i] = xtime(s1_nxt.x2[i]);
      s1_nxt.x8[i] = xtime(s1_nxt.x4[i]);
    end
  end

  // Multiples by 9, b, d, e assembled from the doubled terms captured in stage 1.
  always_comb begin
    k9 = '0;
    kb = '0;
    kd = '0;
    ke = '0;
    for (int i = 0; i < 4; i++) begin
      k9[i] = s1.x8[i] ^ s1.a[i];
      kb[i] = s1.x8[i] ^ s1.x2[i] ^ s1.a[i];
      kd[i] = s1.x8[i] ^ s1.x4[i] ^ s1.a[i];
      ke[i] = s1.x8[i] ^ s1.x4[i] ^ s1.x2[i];
    end
    r    = '0;
    r[0] = ke[0] ^ kb[1] ^ kd[2] ^ k9[3];
    r[1] = k9[0] ^ ke[1] ^ kb[2] ^ kd[3];
    r[2] = kd[0] ^ k9[1] ^ ke[2] ^ kb[3];
    r[3] = kb[0] ^ kd[1] ^ k9[2] ^ ke[3];
    s2_nxt = s1.off ? s1.a : r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= '0;
      s1_vld  <= 1'b0;
      s2_dat  <= '0;
      s2_vld  <= 1'b0;
      col_cnt <= '0;
    end else begin
      if (adv1) begin
        s1_vld <= word_in_inv_sub_bytes_vld;
        if (word_in_inv_sub_bytes_vld) s1 <= s1_nxt;
      end
      if (adv2) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_dat <= s2_nxt;
      end
      if (out_xfer) col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_pipe.sv
// Bench for inv_mix_columns_pipe: directed vectors plus a GF(2^8) matrix reference model
// and a scoreboard that checks every output cycle.
module tb_inv_mix_columns_pipe;

  localparam int WPS   = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [31:0]      in_dat;
  logic             in_vld;
  logic             in_rdy;
  logic             off;
  logic [31:0]      out_dat;
  logic             out_vld;
  logic             out_rdy;
  logic [CNT_W-1:0] col_idx;
  logic             done;

  inv_mix_columns_pipe #(.WORDS_PER_STATE(WPS), .CNT_W(CNT_W)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .word_in_inv_sub_bytes       (in_dat),
    .word_in_inv_sub_bytes_vld   (in_vld),
    .word_in_inv_sub_bytes_rdy   (in_rdy),
    .inv_mix_column_off          (off),
    .word_out_inv_mix_column     (out_dat),
    .word_out_inv_mix_column_vld (out_vld),
    .word_out_inv_mix_column_rdy (out_rdy),
    .word_out_col_idx            (col_idx),
    .state_done                  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q[$];
  logic [2:0]  logq[$];
  int          mcnt = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_dat;
  logic [CNT_W-1:0] prev_idx;
  logic        prev_done;

  logic [31:0] wbuf[16];
  bit          obuf[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Generic GF(2^8) multiply (poly 0x11b) and the InvMixColumns matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_ref(input logic [31:0] w, input bit o);
    logic [7:0] a[4];
    logic [7:0] m[4];
    logic [31:0] res = 32'h0;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    if (o) return w;
    for (int i = 0; i < 4; i++) a[i] = w[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - i + 4) % 4], a[j]);
      res[31-8*i -: 8] = acc;
    end
    return res;
  endfunction

  // Scoreboard: samples on the falling edge, what it sees is what the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", out_vld, 1'b1);
        chk("hold_dat", out_dat, prev_dat);
        chk("hold_idx", col_idx, prev_idx);
        chk("hold_done", done, prev_done);
      end
      if (out_vld) begin
        chk("col_idx", col_idx, mcnt);
        chk("state_done", done, mcnt == WPS - 1);
      end else begin
        chk("idle_dat", out_dat, 32'h0);
        chk("idle_done", done, 1'b0);
      end
      if (out_vld && out_rdy) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: got %h want no word", out_dat);
        end else begin
          chk("data", out_dat, q.pop_front());
        end
        logq.push_back({done, col_idx});
        mcnt = (mcnt + 1) % WPS;
      end
      if (in_vld && in_rdy) q.push_back(inv_mix_ref(in_dat, off));
      prev_stall = out_vld && !out_rdy;
      prev_dat   = out_dat;
      prev_idx   = col_idx;
      prev_done  = done;
    end
  end

  task automatic send_check(input logic [31:0] w, input bit o, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    in_vld = 1'b1; in_dat = w; off = o; out_rdy = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0; in_dat = $urandom();
    chk({nm, "_lat1"}, out_vld, 1'b0);
    @(posedge clk); #1;
    chk({nm, "_vld"}, out_vld, 1'b1);
    chk({nm, "_dat"}, out_dat, exp);
  endtask

  task automatic stream(input int start, input int n, input int vld_pct, input int rdy_pct,
                        input int off_pct, input bit rnd);
    int idx = start;
    int cyc = 0;
    bit pend = 0;
    while (idx < n && cyc < n * 10 + 100) begin
      @(posedge clk); #1;
      if (!pend) begin
        in_vld = ($urandom_range(99) < vld_pct);
        in_dat = rnd ? $urandom() : wbuf[idx % 16];
        off    = rnd ? ($urandom_range(99) < off_pct) : obuf[idx % 16];
      end
      out_rdy = ($urandom_range(99) < rdy_pct);
      #1;
      pend = in_vld && !in_rdy;
      if (in_vld && in_rdy) idx++;
      cyc++;
    end
    if (idx < n) begin
      n_vec++;
      n_err++;
      $display("FAIL stream_timeout: got %0d words want %0d", idx, n);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic drain(input string nm);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk(nm, q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_vld"}, out_vld, 1'b0);
    chk({nm, "_dat"}, out_dat, 32'h0);
    chk({nm, "_idx"}, col_idx, 0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_rdy"}, in_rdy, 1'b1);
  endtask

  initial begin
    int bp_idx;
    int exp_idx[8];
    bit exp_done[8];
    exp_idx  = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_done = '{0, 0, 0, 1, 0, 0, 0, 1};
    wbuf = '{32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h01010101,
             32'h12345678, 32'hdeadbeef, 32'h00000000, 32'hffffffff,
             32'hc0ffee11, 32'h0f0e0d0c, 32'ha5a55a5a, 32'h80808080,
             32'h1b1b1b1b, 32'h7f7f7f7f, 32'h01020304, 32'hfedcba98};
    obuf = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    rst_n = 1'b0; in_vld = 1'b0; in_dat = 32'h0; off = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("por");

    chk("model_v1", inv_mix_ref(32'h8e4da1bc, 1'b0), 32'hdb135345);
    chk("model_v2", inv_mix_ref(32'h9fdc589d, 1'b0), 32'hf20a225c);
    chk("model_v3", inv_mix_ref(32'hd5d5d7d6, 1'b0), 32'hd4d4d4d5);
    chk("model_v4", inv_mix_ref(32'h01010101, 1'b0), 32'h01010101);
    chk("model_byp", inv_mix_ref(32'h8e4da1bc, 1'b1), 32'h8e4da1bc);

    send_check(32'h8e4da1bc, 1'b0, 32'hdb135345, "v1");
    send_check(32'h9fdc589d, 1'b0, 32'hf20a225c, "v2");
    send_check(32'hd5d5d7d6, 1'b0, 32'hd4d4d4d5, "v3");
    send_check(32'h01010101, 1'b0, 32'h01010101, "v4");
    send_check(32'h8e4da1bc, 1'b1, 32'h8e4da1bc, "byp_on");
    send_check(32'h8e4da1bc, 1'b0, 32'hdb135345, "byp_off");

    // Reset with both stages occupied and the column count mid-state.
    @(posedge clk); #1;
    out_rdy = 1'b0; in_vld = 1'b1; in_dat = wbuf[4]; off = 1'b0;
    @(posedge clk); #1;
    in_dat = wbuf[5];
    @(posedge clk); #1;
    chk("pre_rst_full", in_rdy, 1'b0);
    chk("pre_rst_idx", col_idx, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_vld = 1'b0;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    chk("rst_discard", out_vld, 1'b0);
    out_rdy = 1'b1;

    logq.delete();
    stream(0, 8, 100, 100, 0, 1'b0);
    drain("col_drain");
    chk("col_n", logq.size(), 8);
    for (int k = 0; k < 8 && k < logq.size(); k++)
      chk($sformatf("col_seq%0d", k), logq[k], {exp_done[k], exp_idx[k][1:0]});

    bp_idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      out_rdy = 1'b0; in_vld = 1'b1; in_dat = wbuf[bp_idx]; off = obuf[bp_idx];
      #1;
      if (in_rdy) bp_idx++;
    end
    @(posedge clk); #1;
    chk("bp_accepted", bp_idx, 2);
    chk("bp_in_rdy", in_rdy, 1'b0);
    chk("bp_out_vld", out_vld, 1'b1);
    stream(bp_idx, 6, 100, 100, 0, 1'b0);
    drain("bp_drain");

    stream(0, 10000, 70, 70, 20, 1'b1);
    drain("rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
